// File: rtl/rsa_const_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rsa_const_scheduler
// Purpose  : Two decrypt lanes share one Montgomery constant engine
//            (R mod N, R^2 mod N). Lanes are arbitrated round-robin and the
//            engine is launched for the winner. The engine results are
//            captured into holding registers and returned with a one-cycle
//            response pulse to that lane. Even moduli and engine timeouts
//            come back flagged with rsp_err.
// Option   : RSA_CONST_CACHE_EN - remembers the last successfully computed
//            modulus, so a repeat key is answered without relaunching the
//            engine.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            req[1:0]            per-lane request, held until own rsp_valid
//            mod0, mod1          per-lane modulus
//            gnt[1:0]            one-hot grant (CHECK .. RESP)
//            rsp_valid[1:0]      one-cycle response pulse to the granted lane
//            rsp_err             response carries an error (even N / timeout)
//            r_out, t_out        R mod N / R^2 mod N holding registers
//            busy                scheduler not idle
//            eng_start, eng_mod  engine launch pulse and modulus
//            eng_done            engine completion pulse
//            eng_r, eng_t        engine results, sampled on eng_done
// Revision : 1.0 - initial release
// ============================================================================
module rsa_const_scheduler #(
  parameter int DATA_LENGTH = 1024,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req,
  input  logic [DATA_LENGTH-1:0] mod0,
  input  logic [DATA_LENGTH-1:0] mod1,
  output logic [1:0]             gnt,
  output logic [1:0]             rsp_valid,
  output logic                   rsp_err,
  output logic [DATA_LENGTH-1:0] r_out,
  output logic [DATA_LENGTH-1:0] t_out,
  output logic                   busy,
  output logic                   eng_start,
  output logic [DATA_LENGTH-1:0] eng_mod,
  input  logic                   eng_done,
  input  logic [DATA_LENGTH-1:0] eng_r,
  input  logic [DATA_LENGTH-1:0] eng_t
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                 state, state_d;
  logic [DATA_LENGTH-1:0] mod_q;
  logic                   rr_ptr;
  logic                   err_q;
  logic [TO_W-1:0]        cnt;
  logic                   sel;
  logic                   timeout;
  logic                   hit;

  // Both lanes asking: the round-robin pointer decides; else the lone one.
  assign sel     = (req == 2'b11) ? rr_ptr : req[1];
  assign timeout = (cnt == TO_W'(TIMEOUT_CYC - 1));
  // The registered modulus stays put from grant until the next grant,
  // which covers the LAUNCH..WAIT stability window the engine needs.
  assign eng_mod = mod_q;

`ifdef RSA_CONST_CACHE_EN
  logic [DATA_LENGTH-1:0] cache_mod;
  logic                   cache_vld;

  assign hit = cache_vld && (mod_q == cache_mod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_mod <= '0;
      cache_vld <= 1'b0;
    end else if (state == S_WAIT) begin
      if (eng_done) begin
        cache_mod <= mod_q;
        cache_vld <= 1'b1;
      end else if (timeout) begin
        cache_vld <= 1'b0;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    rsp_valid = 2'b00;
    rsp_err   = 1'b0;
    eng_start = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:   if (req != 2'b00) state_d = S_CHECK;
      // Even modulus (including zero) has no Montgomery form: fail fast.
      S_CHECK:  state_d = (!mod_q[0] || hit) ? S_RESP : S_LAUNCH;
      S_LAUNCH: begin
        eng_start = 1'b1;
        state_d   = S_WAIT;
      end
      // Done wins over a coincident timeout.
      S_WAIT:   if (eng_done || timeout) state_d = S_RESP;
      S_RESP: begin
        rsp_valid = gnt;
        rsp_err   = err_q;
        state_d   = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= 2'b00;
      mod_q  <= '0;
      rr_ptr <= 1'b0;
      err_q  <= 1'b0;
      cnt    <= '0;
      r_out  <= '0;
      t_out  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            gnt   <= sel ? 2'b10 : 2'b01;
            mod_q <= sel ? mod1 : mod0;
            err_q <= 1'b0;
          end
        end
        S_CHECK: begin
          if (!mod_q[0]) err_q <= 1'b1;
        end
        S_LAUNCH: begin
          cnt <= '0;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (eng_done) begin
            r_out <= eng_r;
            t_out <= eng_t;
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        S_RESP: begin
          gnt    <= 2'b00;
          // Favour the lane that was not just served.
          rr_ptr <= ~gnt[1];
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rsa_const_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_const_scheduler
// Purpose  : Scoreboard bench for rsa_const_scheduler with a stub engine.
//            Drivers push the expected response (lane, error, R, T and the
//            cycle it must appear in); a negedge monitor pops and compares.
// Option   : honours RSA_CONST_CACHE_EN for the repeat-key expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_const_scheduler;

  localparam int DL  = 16;
  localparam int TO  = 16;
  localparam int TW  = 5;
  localparam int LAT_MISS = 13;  // eng_start at +2, done 10 cycles later, rsp next cycle

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [DL-1:0] mod0 = '0, mod1 = '0;
  logic [1:0]    gnt, rsp_valid;
  logic          rsp_err, busy, eng_start;
  logic [DL-1:0] r_out, t_out, eng_mod;
  logic          eng_done = 1'b0;
  logic [DL-1:0] eng_r = '0, eng_t = '0;

  rsa_const_scheduler #(.DATA_LENGTH(DL), .TIMEOUT_CYC(TO), .TO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mod0(mod0), .mod1(mod1),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .r_out(r_out), .t_out(t_out), .busy(busy),
    .eng_start(eng_start), .eng_mod(eng_mod),
    .eng_done(eng_done), .eng_r(eng_r), .eng_t(eng_t)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            lane;
    bit            err;
    logic [DL-1:0] r;
    logic [DL-1:0] t;
    int            cyc;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_e;
  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int starts = 0;

  // Stub engine controls
  bit            hang = 1'b0;
  logic [DL-1:0] er = 16'h005A, et = 16'h003C;

  always @(posedge clk) begin
    ncyc <= ncyc + 1;
    if (eng_start) starts <= starts + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Stub engine: done pulse 10 cycles after the start pulse unless hung.
  initial forever begin
    @(negedge clk);
    if (eng_start && !hang) begin
      repeat (10) @(negedge clk);
      eng_r = er; eng_t = et; eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n && rsp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_lane", {30'd0, rsp_valid}, mon_e.lane ? 32'd2 : 32'd1);
        check("rsp_err",  {31'd0, rsp_err}, {31'd0, mon_e.err});
        check("r_out",    {16'd0, r_out}, {16'd0, mon_e.r});
        check("t_out",    {16'd0, t_out}, {16'd0, mon_e.t});
        check("rsp_cycle", ncyc, mon_e.cyc);
      end
    end
  end

  task automatic serve(input bit lane, input logic [DL-1:0] m, input bit err,
                       input logic [DL-1:0] r, input logic [DL-1:0] t,
                       input int lat, input int nstart);
    int t0, s0;
    bit seen;
    @(negedge clk);
    if (lane) mod1 = m; else mod0 = m;
    req[lane] = 1'b1;
    t0 = ncyc;
    s0 = starts;
    sb.push_back(rsp_t'{lane, err, r, t, t0 + lat});
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid[lane]) seen = 1'b1;
    end
    req[lane] = 1'b0;
    check("rsp_seen", {31'd0, seen}, 32'd1);
    check("eng_starts", starts - s0, nstart);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_gnt"},  {30'd0, gnt}, 32'd0);
    check({tag, "_rspv"}, {30'd0, rsp_valid}, 32'd0);
    check({tag, "_rspe"}, {31'd0, rsp_err}, 32'd0);
    check({tag, "_r"},    {16'd0, r_out}, 32'd0);
    check({tag, "_t"},    {16'd0, t_out}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_start"},{31'd0, eng_start}, 32'd0);
    check({tag, "_emod"}, {16'd0, eng_mod}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s0;
    rst_n = 1'b0;
    #12;
    chk_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: lane 0, lane 1, lane 0 (even moduli, fast path)
    @(negedge clk);
    mod0 = 16'h0002; mod1 = 16'h0004; req = 2'b11;
    t0 = ncyc;
    sb.push_back(rsp_t'{1'b0, 1'b1, 16'h0, 16'h0, t0 + 2});
    sb.push_back(rsp_t'{1'b1, 1'b1, 16'h0, 16'h0, t0 + 5});
    sb.push_back(rsp_t'{1'b0, 1'b1, 16'h0, 16'h0, t0 + 8});
    repeat (8) @(negedge clk);
    req = 2'b00;
    repeat (2) @(negedge clk);
    check("contention_drained", sb.size(), 0);

    // Miss
    serve(1'b0, 16'h00F7, 1'b0, 16'h005A, 16'h003C, LAT_MISS, 1);
    check("eng_mod_miss", {16'd0, eng_mod}, 32'h00F7);

    // Repeat key
`ifdef RSA_CONST_CACHE_EN
    serve(1'b0, 16'h00F7, 1'b0, 16'h005A, 16'h003C, 2, 0);
`else
    serve(1'b0, 16'h00F7, 1'b0, 16'h005A, 16'h003C, LAT_MISS, 1);
`endif

    // Even modulus on lane 1
    serve(1'b1, 16'h0100, 1'b1, 16'h005A, 16'h003C, 2, 0);

    // Timeout: engine hangs
    hang = 1'b1;
    serve(1'b1, 16'h1235, 1'b1, 16'h005A, 16'h003C, 3 + TO, 1);

    // Late done while idle must be ignored
    @(negedge clk);
    eng_r = 16'hFFFF; eng_t = 16'hFFFF; eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    repeat (2) @(negedge clk);
    check("late_busy", {31'd0, busy}, 32'd0);
    check("late_r", {16'd0, r_out}, 32'h005A);
    check("late_t", {16'd0, t_out}, 32'h003C);

    // Cache invalidated by the timeout: the old key relaunches
    hang = 1'b0; er = 16'h0011; et = 16'h0022;
    serve(1'b0, 16'h00F7, 1'b0, 16'h0011, 16'h0022, LAT_MISS, 1);

    // Reset in the middle of WAIT
    hang = 1'b1;
    @(negedge clk);
    mod0 = 16'h00F1; req = 2'b01;
    s0 = starts;
    repeat (4) @(negedge clk);
    check("midwait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_starts", starts - s0, 1);
    hang = 1'b0;

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
